brcomp_iter: RTL and testbench
==============================

Name: brcomp_iter

Overview:
Parametrised, multi-cycle branch comparator for the execute stage. It accepts two DATA_W operands plus a RISC-V branch funct3 through a valid/ready handshake. It compares CHUNK_W bits per cycle from MSB to LSB, stopping early at the first differing chunk, and returns less, equal and a decoded taken flag through a second valid/ready handshake. Intended for wide or area-constrained cores where a single-cycle full-width compare does not meet timing.

Parameters:
DATA_W, 32, operand width in bits; must be a multiple of CHUNK_W.
CHUNK_W, 8, bits compared per cycle; NCHUNK = DATA_W/CHUNK_W, and NCHUNK >= 1.
EARLY_EXIT, 1, 1 = finish at the first differing chunk; 0 = always scan all NCHUNK chunks (fixed latency).
TAG_W, 4, width of the sideband tag carried from input to output.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous abort of any operation in flight.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
rs1_data  in  DATA_W  operand A.
rs2_data  in  DATA_W  operand B.
br_op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  result consumed when out_valid && out_ready.
br_less  out  1  rs1 < rs2 (signed if br_op[1]=0, unsigned if br_op[1]=1).
br_equal  out  1  rs1 == rs2.
br_taken  out  1  branch condition for br_op.
br_illegal  out  1  br_op was 010 or 011.
out_tag  out  TAG_W  in_tag of this result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, br_less, br_equal, br_taken, br_illegal, out_tag all 0; in_ready=1.
- in_ready is 1 only in IDLE. There is exactly one operation in flight, with no overlap.
- FSM IDLE -> CMP on accept. On accept, latch the operands, br_op and in_tag, and set chunk index idx=NCHUNK-1.
- Signed ops: at accept, invert bit DATA_W-1 of both latched operands. All later compares are unsigned.
- CMP, per cycle: compare chunk idx of A against chunk idx of B.
  - If the chunks differ and EARLY_EXIT=1: latch less=(A_chunk<B_chunk), equal=0, go to DONE.
  - If the chunks differ and EARLY_EXIT=0: record less from the first differing chunk only, clear equal, and keep scanning.
  - When idx=0 is done: go to DONE; if no chunk differed, less=0 and equal=1.
- Latency: out_valid is high after the k-th edge following the accepting edge, where k = number of chunks examined. k is 1..NCHUNK with EARLY_EXIT=1, and always NCHUNK with EARLY_EXIT=0.
- DONE: out_valid=1. All outputs stay stable until out_ready. On handshake, go to IDLE (in_ready=1 next cycle). There is no same-cycle re-accept.
- br_taken decode: BEQ=eq, BNE=!eq, BLT/BLTU=less, BGE/BGEU=!less. Illegal op gives taken=0 and illegal=1; less and equal are still computed.
- flush (priority over all else): state goes to IDLE next edge, out_valid is cleared, and the latched result is discarded. flush in IDLE has no effect, and an in_valid in the same cycle is ignored.
- Async reset mid-operation: immediate return to the reset values; no result is produced.
- Outputs are registered. No combinational path from inputs to out_valid or to the results.

Decomposition:
- brcomp_pkg:
  - br_op_e enum (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - state_e enum (IDLE, CMP, DONE).
  - taken-decode function.
- Sub-module brcomp_chunk: combinational CHUNK_W unsigned compare with outputs lt and eq. Instantiated once and muxed by idx.

Test Plan:
1. BLT rs1=0xFFFFFFFF, rs2=0x00000001 (defaults) -> out_valid 1 cycle after accept; less=1, eq=0, taken=1.
2. BEQ rs1=rs2=0x12345678 -> out_valid 4 cycles after accept; eq=1, less=0, taken=1. BNE with the same operands -> taken=0.
3. BLTU 0x00000001 vs 0x00000002 -> decided at chunk 0, 4 cycles; less=1, taken=1. BGEU 0x80000000 vs 0x7FFFFFFF -> 1 cycle, less=0, taken=1.
4. EARLY_EXIT=0, BGE 0x80000000 vs 0x00000000 -> always 4 cycles; less=1, taken=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs and out_tag stable, in_ready=0, second request stalled. Release -> handshake, then in_ready=1 next cycle.
6. Aborts and illegal op:
   - flush in the 2nd CMP cycle of BEQ -> out_valid never rises, in_ready=1 next cycle.
   - rst_n low mid-CMP -> all outputs 0 immediately.
   - br_op=010 -> illegal=1, taken=0.

Source files
------------

// File: rtl/brcomp_pkg.sv
// Shared types and the branch-condition decode for the iterative branch comparator.
package brcomp_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic br_is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic br_taken_f(input logic [2:0] op, input logic less, input logic eq);
        logic t;
        case (op)
            BEQ:        t = eq;
            BNE:        t = !eq;
            BLT, BLTU:  t = less;
            BGE, BGEU:  t = !less;
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brcomp_iter_chunk.sv
// One CHUNK_W-bit unsigned compare slice; the top muxes the active chunk into it.
module brcomp_chunk #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    output logic               lt,
    output logic               eq
);
    assign lt = a < b;
    assign eq = a == b;
endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle branch comparator: scans operands MSB chunk first, optionally
// stopping at the first differing chunk, and returns less/equal/taken.
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CHUNK_W    = 8,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [2:0]        br_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              br_less,
    output logic              br_equal,
    output logic              br_taken,
    output logic              br_illegal,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCHUNK - 1);
    localparam logic [DATA_W-1:0] SIGN_MASK = DATA_W'(1) << (DATA_W - 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               seen_q, seen_d;       // a differing chunk has been found
    logic               seen_lt_q, seen_lt_d; // less from the first differing chunk
    logic               valid_q, valid_d;
    logic               less_q, less_d, equal_q, equal_d;
    logic               taken_q, taken_d, illegal_q, illegal_d;

    logic [CHUNK_W-1:0] chunk_a, chunk_b;
    logic               chunk_lt, chunk_eq;
    logic               fin_less, fin_eq;

    assign chunk_a = CHUNK_W'(a_q >> (idx_q * CHUNK_W));
    assign chunk_b = CHUNK_W'(b_q >> (idx_q * CHUNK_W));

    brcomp_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        seen_lt_d = seen_lt_q;
        valid_d   = valid_q;
        less_d    = less_q;
        equal_d   = equal_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        // Earlier differing chunk dominates; otherwise the current chunk decides.
        fin_less  = seen_q ? seen_lt_q : chunk_lt;
        fin_eq    = !seen_q && chunk_eq;

        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    // Biasing the sign bit turns signed order into unsigned order.
                    a_d       = br_op[1] ? rs1_data : (rs1_data ^ SIGN_MASK);
                    b_d       = br_op[1] ? rs2_data : (rs2_data ^ SIGN_MASK);
                    op_d      = br_op;
                    tag_d     = in_tag;
                    idx_d     = LAST_IDX;
                    seen_d    = 1'b0;
                    seen_lt_d = 1'b0;
                    state_d   = CMP;
                end
                CMP: begin
                    if (!chunk_eq && !seen_q) begin
                        seen_d    = 1'b1;
                        seen_lt_d = chunk_lt;
                    end
                    if ((idx_q == '0) || (EARLY_EXIT && !chunk_eq)) begin
                        state_d   = DONE;
                        valid_d   = 1'b1;
                        less_d    = fin_less;
                        equal_d   = fin_eq;
                        illegal_d = br_is_illegal(op_q);
                        taken_d   = br_taken_f(op_q, fin_less, fin_eq);
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            idx_q     <= '0;
            seen_q    <= 1'b0;
            seen_lt_q <= 1'b0;
            valid_q   <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            idx_q     <= idx_d;
            seen_q    <= seen_d;
            seen_lt_q <= seen_lt_d;
            valid_q   <= valid_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign br_less    = less_q;
    assign br_equal   = equal_q;
    assign br_taken   = taken_q;
    assign br_illegal = illegal_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_brcomp_iter.sv
// Directed bench: early-exit instance (u0) and fixed-latency instance (u1).
module tb_brcomp_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [2:0]  op = '0;
    logic [3:0]  tag = '0;

    logic       ir0, ov0, ls0, eq0, tk0, il0;
    logic       ir1, ov1, ls1, eq1, tk1, il1;
    logic [3:0] ot0, ot1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    brcomp_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b1), .TAG_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(ir0),
        .rs1_data(rs1), .rs2_data(rs2), .br_op(op), .in_tag(tag),
        .out_valid(ov0), .out_ready(out_ready), .br_less(ls0), .br_equal(eq0),
        .br_taken(tk0), .br_illegal(il0), .out_tag(ot0));

    brcomp_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b0), .TAG_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(ir1),
        .rs1_data(rs1), .rs2_data(rs2), .br_op(op), .in_tag(tag),
        .out_valid(ov1), .out_ready(out_ready), .br_less(ls1), .br_equal(eq1),
        .br_taken(tk1), .br_illegal(il1), .out_tag(ot1));

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Issue one op on instance sel, measure latency, check results, then drain.
    task automatic run_op(input int sel, input string name, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                          input int lat, input int l, input int e, input int tk, input int il);
        int n;
        logic v;
        @(negedge clk);
        chk({name, ".in_ready"}, int'(sel ? ir1 : ir0), 1);
        rs1 = a; rs2 = b; op = o; tag = t;
        if (sel != 0) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk);
        #1 in_valid0 = 1'b0; in_valid1 = 1'b0;
        n = 0;
        v = 1'b0;
        while (!v && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            v = sel ? ov1 : ov0;
        end
        chk({name, ".latency"}, n, lat);
        chk({name, ".less"},    int'(sel ? ls1 : ls0), l);
        chk({name, ".equal"},   int'(sel ? eq1 : eq0), e);
        chk({name, ".taken"},   int'(sel ? tk1 : tk0), tk);
        chk({name, ".illegal"}, int'(sel ? il1 : il0), il);
        chk({name, ".tag"},     int'(sel ? ot1 : ot0), int'(t));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({name, ".ready_after"}, int'(sel ? ir1 : ir0), 1);
        chk({name, ".valid_after"}, int'(sel ? ov1 : ov0), 0);
    endtask

    initial begin
        int n;
        #12;
        chk("rst.in_ready", int'(ir0), 1);
        chk("rst.out_valid", int'(ov0), 0);
        chk("rst.outs", int'({ls0, eq0, tk0, il0}), 0);
        chk("rst.tag", int'(ot0), 0);
        chk("rst.u1_valid", int'(ov1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        //        sel name     op      rs1           rs2           tag lat l e tk il
        run_op(0, "blt",   3'b100, 32'hFFFFFFFF, 32'h00000001, 4'h1, 1, 1, 0, 1, 0);
        run_op(0, "beq",   3'b000, 32'h12345678, 32'h12345678, 4'h2, 4, 0, 1, 1, 0);
        run_op(0, "bne",   3'b001, 32'h12345678, 32'h12345678, 4'h3, 4, 0, 1, 0, 0);
        run_op(0, "bltu",  3'b110, 32'h00000001, 32'h00000002, 4'h4, 4, 1, 0, 1, 0);
        run_op(0, "bgeu",  3'b111, 32'h80000000, 32'h7FFFFFFF, 4'h5, 1, 0, 0, 1, 0);
        run_op(0, "blt_mid", 3'b100, 32'h00FF0000, 32'h00FE0000, 4'h6, 2, 0, 0, 0, 0);
        run_op(0, "illegal", 3'b010, 32'h00000005, 32'h00000003, 4'h7, 4, 0, 0, 0, 1);
        run_op(1, "ee0_bge", 3'b101, 32'h80000000, 32'h00000000, 4'h8, 4, 1, 0, 0, 0);
        run_op(1, "ee0_bltu", 3'b110, 32'h01000000, 32'h00FFFFFF, 4'h9, 4, 0, 0, 0, 0);

        // Backpressure: result held while a second request waits.
        @(negedge clk);
        rs1 = 32'h0000_0010; rs2 = 32'h0000_0020; op = 3'b100; tag = 4'hA;
        in_valid0 = 1'b1;
        @(posedge clk);
        #1 rs1 = 32'hFFFF_FFFF; rs2 = 32'h0; tag = 4'hB;
        n = 0;
        while (!ov0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp.valid_rises", int'(ov0), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.valid", int'(ov0), 1);
            chk("bp.in_ready", int'(ir0), 0);
            chk("bp.result", int'({ls0, eq0, tk0, il0}), 4'b1010);
            chk("bp.tag", int'(ot0), 10);
        end
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.ready_after", int'(ir0), 1);
        chk("bp.valid_after", int'(ov0), 0);

        // Flush in IDLE with a simultaneous request: request must be dropped.
        @(negedge clk);
        flush = 1'b1; in_valid0 = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid0 = 1'b0;
        @(negedge clk);
        chk("flush_idle.in_ready", int'(ir0), 1);
        @(negedge clk);
        chk("flush_idle.no_valid", int'(ov0), 0);

        // Flush during the 2nd CMP cycle of a 4-cycle BEQ.
        @(negedge clk);
        rs1 = 32'h12345678; rs2 = 32'h12345678; op = 3'b000; tag = 4'hC;
        in_valid0 = 1'b1;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush.in_ready", int'(ir0), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush.no_valid", int'(ov0), 0);
        end

        // Async reset mid-CMP, after a completed op left nonzero results.
        run_op(0, "pre_rst", 3'b110, 32'h00000001, 32'h00000002, 4'hD, 4, 1, 0, 1, 0);
        @(negedge clk);
        in_valid0 = 1'b1; tag = 4'hE;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.in_ready", int'(ir0), 1);
        chk("arst.out_valid", int'(ov0), 0);
        chk("arst.outs", int'({ls0, eq0, tk0, il0}), 0);
        chk("arst.tag", int'(ot0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst.no_valid", int'(ov0), 0);
        end
        run_op(0, "post_rst", 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 4, 0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
